// File: rtl/row_scan_sequencer.sv
// ============================================================================
// Module   : row_scan_sequencer
// Purpose  : Walks a memory row range through the memory_reader handshake and
//            serializes each captured row into OUT_WIDTH valid/ready beats.
// Revision : 1.0
// ============================================================================
`default_nettype none

module row_scan_sequencer #(
    parameter int WORD_WIDTH = 512,
    parameter int NUM_ROWS   = 128,
    parameter int OUT_WIDTH  = 64,
    parameter int ROW_W      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ROW_W-1:0]      first_row,
    input  logic [ROW_W-1:0]      last_row,
    output logic                  busy,
    output logic                  done,
    output logic                  range_err,
    output logic                  scan_en,
    output logic [ROW_W-1:0]      row_counter_out,
    input  logic                  scan_done,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [ROW_W-1:0]      out_row,
    output logic                  out_last_beat,
    output logic                  out_last_row
);

    localparam int BEATS  = WORD_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] C_BEAT_ONE  = BEAT_W'(1);
    localparam logic [ROW_W-1:0]  C_ROW_ONE   = ROW_W'(1);
    localparam logic [ROW_W:0]    C_NUM_ROWS  = (ROW_W + 1)'(NUM_ROWS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_DRAIN = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ROW_W-1:0]      r_cur_row;
    logic [ROW_W-1:0]      r_last_row;
    logic [WORD_WIDTH-1:0] r_buf;
    logic [BEAT_W-1:0]     r_beat;

    logic                  w_range_bad;
    logic                  w_capture;
    logic                  w_row_end;
    logic                  w_at_last_row;
    logic [BEAT_W-1:0]     w_sel;
    logic [OUT_WIDTH-1:0]  w_beat_data;

    assign w_range_bad   = (first_row > last_row) || ({1'b0, last_row} >= C_NUM_ROWS);
    // Capture only once our own request is visible, so a stale scan_done never latches.
    assign w_capture     = (r_state == S_REQ) && scan_en && scan_done;
    assign w_at_last_row = (r_cur_row == r_last_row);
    assign w_row_end     = (r_state == S_DRAIN) && out_valid && out_ready && (r_beat == C_LAST_BEAT);
    // Beat to present next: the current one on the first DRAIN cycle, the following one after a handshake.
    assign w_sel         = out_valid ? (r_beat + C_BEAT_ONE) : r_beat;
    assign w_beat_data   = r_buf[w_sel * OUT_WIDTH +: OUT_WIDTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = w_range_bad ? S_ERR : S_REQ;
            S_REQ:   if (w_capture) w_next_state = S_DRAIN;
            S_DRAIN: if (w_row_end) w_next_state = w_at_last_row ? S_DONE : S_GAP;
            S_GAP:   if (!scan_done) w_next_state = S_REQ;
            S_DONE:  w_next_state = S_IDLE;
            S_ERR:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cur_row       <= '0;
            r_last_row      <= '0;
            r_buf           <= '0;
            r_beat          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            range_err       <= 1'b0;
            scan_en         <= 1'b0;
            row_counter_out <= '0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_row         <= '0;
            out_last_beat   <= 1'b0;
            out_last_row    <= 1'b0;
        end else begin
            busy            <= (w_next_state == S_REQ) || (w_next_state == S_DRAIN) ||
                               (w_next_state == S_GAP);
            done            <= (w_next_state == S_DONE) || (w_next_state == S_ERR);
            range_err       <= (w_next_state == S_ERR);
            scan_en         <= (r_state == S_REQ) && !w_capture;
            row_counter_out <= r_cur_row;

            if ((r_state == S_IDLE) && start && !w_range_bad) begin
                r_cur_row  <= first_row;
                r_last_row <= last_row;
            end

            if (w_capture) begin
                r_buf  <= data_in;
                r_beat <= '0;
            end

            if (r_state == S_DRAIN) begin
                if (!out_valid) begin
                    out_valid     <= 1'b1;
                    out_data      <= w_beat_data;
                    out_row       <= r_cur_row;
                    out_last_beat <= (w_sel == C_LAST_BEAT);
                    out_last_row  <= w_at_last_row;
                end else if (out_ready) begin
                    if (r_beat == C_LAST_BEAT) begin
                        out_valid     <= 1'b0;
                        out_last_beat <= 1'b0;
                        out_last_row  <= 1'b0;
                        if (!w_at_last_row) begin
                            r_cur_row <= r_cur_row + C_ROW_ONE;
                        end
                    end else begin
                        r_beat        <= w_sel;
                        out_data      <= w_beat_data;
                        out_last_beat <= (w_sel == C_LAST_BEAT);
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
